sd_rx_gigmac: RTL and testbench

Receive half of the gigabit Ethernet MAC mock-up. The block samples a GMII receive stream, strips the preamble and SFD, and checks the CRC-32 FCS. It presents each frame byte-by-byte on an srdy/drdy output carrying internal packet codes (SOP/MOT/EOP/BADEOP) toward the bridge core. Frames the core cannot accept in time are truncated and terminated with BADEOP.

---
 rtl/sd_rx_gigmac.sv | 157 +++++++++++++++
 tb/tb_sd_rx_gigmac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sd_rx_gigmac.sv
// GMII receive side of the gigabit MAC mock-up: strips preamble/SFD, checks the
// CRC-32 FCS and hands frame bytes to the core as SOP/MOT/EOP/BADEOP codes.
module sd_rx_gigmac (
  input  logic       clk,
  input  logic       reset,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       rxg_srdy,
  input  logic       rxg_drdy,
  output logic [1:0] rxg_code,
  output logic [7:0] rxg_data
);

  localparam logic [1:0]  PCC_SOP     = 2'd0;
  localparam logic [1:0]  PCC_MOT     = 2'd1;
  localparam logic [1:0]  PCC_EOP     = 2'd2;
  localparam logic [1:0]  PCC_BADEOP  = 2'd3;
  localparam logic [7:0]  GMII_PRE    = 8'h55;
  localparam logic [7:0]  GMII_SFD    = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_PREAMBLE = 4'b0010,
    S_PAYLOAD  = 4'b0100,
    S_DROP     = 4'b1000
  } state_t;

  state_t      state, state_n;
  logic [31:0] crc, crc_n;
  logic        hold_vld, hold_vld_n;
  logic [7:0]  hold_data, hold_data_n;
  logic        sop_sent, sop_sent_n;
  logic        err, err_n;
  logic        pend_bad, pend_bad_n;
  logic        srdy_n;
  logic [1:0]  code_n;
  logic [7:0]  data_n;
  logic        push, can_load, frame_ok;
  logic [1:0]  push_code;

  // MSB-first register fed LSB-first data bits: the register is the bit-mirror
  // of the usual reflected CRC, hence the C704DD7B residue.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    hold_vld_n  = hold_vld;
    hold_data_n = hold_data;
    sop_sent_n  = sop_sent;
    err_n       = err;
    pend_bad_n  = pend_bad;
    srdy_n      = rxg_srdy;
    code_n      = rxg_code;
    data_n      = rxg_data;
    push        = 1'b0;
    push_code   = PCC_MOT;
    can_load    = !rxg_srdy || rxg_drdy;
    frame_ok    = can_load && !pend_bad;

    if (rxg_srdy && rxg_drdy) srdy_n = 1'b0;
    // A pending truncation marker owns the register before any new frame data.
    if (pend_bad && can_load) begin
      srdy_n     = 1'b1;
      code_n     = PCC_BADEOP;
      data_n     = 8'h00;
      pend_bad_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (gmii_rx_dv) state_n = (gmii_rxd == GMII_PRE) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv) state_n = S_IDLE;
        else if (gmii_rxd == GMII_SFD) begin
          state_n    = S_PAYLOAD;
          hold_vld_n = 1'b0;
          sop_sent_n = 1'b0;
          crc_n      = 32'hFFFFFFFF;
          err_n      = 1'b0;
        end else if (gmii_rxd != GMII_PRE) state_n = S_DROP;
      end
      S_PAYLOAD: begin
        if (gmii_rx_dv) begin
          crc_n = crc_byte(crc, gmii_rxd);
          if (gmii_rx_er) err_n = 1'b1;
          push        = hold_vld;
          push_code   = sop_sent ? PCC_MOT : PCC_SOP;
          hold_vld_n  = 1'b1;
          hold_data_n = gmii_rxd;
        end else begin
          state_n    = S_IDLE;
          hold_vld_n = 1'b0;
          push       = hold_vld;
          push_code  = (crc == CRC_RESIDUE && !err) ? PCC_EOP : PCC_BADEOP;
        end
      end
      S_DROP: begin
        if (!gmii_rx_dv) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (push) begin
      if (frame_ok) begin
        srdy_n     = 1'b1;
        code_n     = push_code;
        data_n     = hold_data;
        sop_sent_n = 1'b1;
      end else begin
        // Overflow: silent discard before SOP, otherwise terminate with BADEOP.
        state_n    = gmii_rx_dv ? S_DROP : S_IDLE;
        hold_vld_n = 1'b0;
        if (sop_sent) pend_bad_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      crc       <= 32'hFFFFFFFF;
      hold_vld  <= 1'b0;
      hold_data <= 8'h00;
      sop_sent  <= 1'b0;
      err       <= 1'b0;
      pend_bad  <= 1'b0;
      rxg_srdy  <= 1'b0;
      rxg_code  <= 2'd0;
      rxg_data  <= 8'h00;
    end else begin
      state     <= state_n;
      crc       <= crc_n;
      hold_vld  <= hold_vld_n;
      hold_data <= hold_data_n;
      sop_sent  <= sop_sent_n;
      err       <= err_n;
      pend_bad  <= pend_bad_n;
      rxg_srdy  <= srdy_n;
      rxg_code  <= code_n;
      rxg_data  <= data_n;
    end
  end

endmodule

// File: tb/tb_sd_rx_gigmac.sv
// Directed bench for sd_rx_gigmac: good/bad frames, rx_er, back-pressure
// truncation, aborted preambles and mid-frame reset.
module tb_sd_rx_gigmac;
  localparam logic [1:0] SOP = 2'd0, MOT = 2'd1, EOP = 2'd2, BAD = 2'd3;

  logic       clk = 1'b0;
  logic       reset, dv, er, drdy;
  logic [7:0] rxd;
  logic       srdy;
  logic [1:0] code;
  logic [7:0] data;

  sd_rx_gigmac dut (
    .clk(clk), .reset(reset), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rxd(rxd),
    .rxg_srdy(srdy), .rxg_drdy(drdy), .rxg_code(code), .rxg_data(data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: inputs change just after posedge, so negedge sees the
  // srdy/drdy pair that the next posedge will act on.
  logic [9:0] cap[$];
  int         rise_cyc = -1;
  logic       srdy_q = 1'b0;
  always @(negedge clk) begin
    if (srdy && drdy) cap.push_back({code, data});
    if (srdy && !srdy_q) rise_cyc = cyc;
    srdy_q = srdy;
  end

  int         vectors = 0, miscompares = 0;
  logic [7:0] fb[64];
  int         t_b0, base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input bit bad_fcs);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      fb[i] = 8'h10 + 8'(i);
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fb[60] = c[7:0]; fb[61] = c[15:8]; fb[62] = c[23:16]; fb[63] = c[31:24];
    if (bad_fcs) fb[63] = fb[63] ^ 8'h01;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    dv = v; rxd = d; er = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_frame(input bit bad_fcs, input int er_idx, input int stall_idx,
                            input int rst_idx, input int gap);
    build_frame(bad_fcs);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      dv = 1'b1; rxd = fb[i]; er = (i == er_idx);
      drdy = !(stall_idx >= 0 && i >= stall_idx && i < stall_idx + 3);
      reset = (i == rst_idx);
      if (i == 0) t_b0 = cyc;
      if (i == rst_idx) begin
        #1;
        chk("async_reset_srdy", {31'b0, srdy}, 32'd0);
      end
    end
    reset = 1'b0; drdy = 1'b1;
    idle(gap);
  endtask

  task automatic check_stream(input string tag, input int b, input logic [1:0] last_code);
    logic [1:0] ec;
    for (int i = 0; i < 64; i++) begin
      ec = (i == 0) ? SOP : (i == 63) ? last_code : MOT;
      if (b + i < cap.size()) chk(tag, {22'b0, cap[b + i]}, {22'b0, ec, fb[i]});
      else chk({tag, "_missing"}, 32'(b + i), 32'(cap.size()));
    end
  endtask

  initial begin
    reset = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00; drdy = 1'b1;
    #1;
    chk("reset_srdy", {31'b0, srdy}, 32'd0);
    chk("reset_code", {30'b0, code}, 32'd0);
    chk("reset_data", {24'b0, data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Good frame
    base = cap.size();
    send_frame(1'b0, -1, -1, -1, 1); idle(4);
    chk("good_count", 32'(cap.size() - base), 32'd64);
    check_stream("good", base, EOP);
    chk("good_latency", 32'(rise_cyc - t_b0), 32'd2);
    chk("good_idle_srdy", {31'b0, srdy}, 32'd0);

    // Corrupted FCS
    base = cap.size();
    send_frame(1'b1, -1, -1, -1, 1); idle(4);
    chk("badfcs_count", 32'(cap.size() - base), 32'd64);
    check_stream("badfcs", base, BAD);

    // rx_er on payload byte 10
    base = cap.size();
    send_frame(1'b0, 10, -1, -1, 1); idle(4);
    chk("rxer_count", 32'(cap.size() - base), 32'd64);
    check_stream("rxer", base, BAD);

    // Back-pressure truncation, then a clean frame after a 1-cycle gap
    base = cap.size();
    send_frame(1'b0, -1, 5, -1, 1);
    send_frame(1'b0, -1, -1, -1, 1); idle(4);
    chk("stall_count", 32'(cap.size() - base), 32'd69);
    if (cap.size() >= base + 69) begin
      chk("stall_sop",  {22'b0, cap[base]},     {22'b0, SOP, 8'h10});
      chk("stall_mot1", {22'b0, cap[base + 1]}, {22'b0, MOT, 8'h11});
      chk("stall_mot3", {22'b0, cap[base + 3]}, {22'b0, MOT, 8'h13});
      chk("stall_bad",  {22'b0, cap[base + 4]}, {22'b0, BAD, 8'h00});
      check_stream("after_stall", base + 5, EOP);
    end

    // Back-to-back frames with a single idle gap
    base = cap.size();
    send_frame(1'b0, -1, -1, -1, 1);
    send_frame(1'b0, -1, -1, -1, 1); idle(4);
    chk("b2b_count", 32'(cap.size() - base), 32'd128);
    check_stream("b2b_a", base, EOP);
    check_stream("b2b_b", base + 64, EOP);

    // Empty frame and a frame that does not start with preamble
    base = cap.size();
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'hD5); idle(3);
    chk("empty_frame", 32'(cap.size() - base), 32'd0);
    drive(1'b1, 8'hAB); drive(1'b1, 8'h55); drive(1'b1, 8'hD5);
    drive(1'b1, 8'h11); drive(1'b1, 8'h22); idle(1);
    chk("nonpre_frame", 32'(cap.size() - base), 32'd0);
    send_frame(1'b0, -1, -1, -1, 1); idle(4);
    chk("after_drop_count", 32'(cap.size() - base), 32'd64);
    check_stream("after_drop", base, EOP);

    // Reset at payload byte 20, then a fresh frame
    base = cap.size();
    send_frame(1'b0, -1, -1, 20, 1); idle(4);
    chk("rst_count", 32'(cap.size() - base), 32'd18);
    if (cap.size() >= base + 18) begin
      chk("rst_first", {22'b0, cap[base]},      {22'b0, SOP, 8'h10});
      chk("rst_last",  {22'b0, cap[base + 17]}, {22'b0, MOT, 8'h21});
    end
    chk("rst_idle_srdy", {31'b0, srdy}, 32'd0);
    base = cap.size();
    send_frame(1'b0, -1, -1, -1, 1); idle(4);
    chk("post_rst_count", 32'(cap.size() - base), 32'd64);
    check_stream("post_rst", base, EOP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
